// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG front-end blocks.
//   CONV_LAT : pipeline depth of the RGB->YCbCr converter (enable-stalled stages)
//   BLK_PIX  : pixels per 8x8 block
//   rgb_t    : [23:16]=R [15:8]=G [7:0]=B
//   ycc_t    : [23:16]=Cr [15:8]=Cb [7:0]=Y
package jpeg_pkg;

   localparam int unsigned CONV_LAT = 3;
   localparam int unsigned BLK_PIX  = 64;
   localparam int unsigned PIX_BITS = 24;

   typedef logic [PIX_BITS-1:0] rgb_t;
   typedef logic [PIX_BITS-1:0] ycc_t;

endpackage

// File: rtl/ycc_sync_fifo.sv
// Synchronous FIFO with occupancy count; holds converter results until downstream accepts.
//   clk, rst (async, active-low), clr (sync flush)
//   push/din  : write side (ignored when full)
//   pop       : read side (ignored when empty)
//   head_c    : combinational view of the oldest entry
//   count     : registered number of stored entries
module ycc_sync_fifo #(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_c,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & (count != CNT_W'(DEPTH));
   assign do_pop  = pop & (count != '0);
   assign head_c  = mem[rd_ptr];

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; entries are only visible once counted.
   always_ff @(posedge clk) begin
      if (do_push && !clr) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ycc_stream_sched.sv
// Schedules a valid/ready RGB stream through the enable-stalled RGB->YCbCr converter
// and presents the results as a valid/ready YCbCr stream with 8x8 block / frame markers.
//   clk, rst (async, active-low), clr (sync soft clear)
//   in_valid/in_ready/in_rgb            : RGB pixel input
//   conv_rst/conv_enable/conv_data_in   : converter control and data
//   conv_data_out                       : converter result
//   out_valid/out_ready/out_ycc         : YCbCr pixel output (FIFO head)
//   out_blk_first/out_blk_last          : head is pixel 0 / 63 of a block
//   out_frm_last                        : head is the last pixel of the frame
//   busy                                : work in flight or converter in reset
module ycc_stream_sched
   import jpeg_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned BLK_PER_FRAME = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic in_valid,
   output logic in_ready,
   input  rgb_t in_rgb,
   output logic conv_rst,
   output logic conv_enable,
   output rgb_t conv_data_in,
   input  ycc_t conv_data_out,
   output logic out_valid,
   input  logic out_ready,
   output ycc_t out_ycc,
   output logic out_blk_first,
   output logic out_blk_last,
   output logic out_frm_last,
   output logic busy
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned PIX_W = $clog2(BLK_PIX);
   localparam int unsigned BLK_W = (BLK_PER_FRAME > 1) ? $clog2(BLK_PER_FRAME) : 1;

   logic [CONV_LAT-1:0] tag;
   logic                conv_rst_q;
   logic [CNT_W-1:0]    fifo_count;
   logic [CNT_W:0]      inflight;
   logic [PIX_W-1:0]    pix;
   logic [BLK_W-1:0]    blk;
   logic                in_fire;
   logic                push;
   logic                pop;
   logic                pix_last;
   logic                blk_last;
   ycc_t                fifo_head;

   // Credit: FIFO entries plus pixels still inside the converter.
   // A same-cycle pop is deliberately not counted, so the FIFO can never overflow.
   always_comb begin
      inflight = (CNT_W+1)'(fifo_count);
      for (int i = 0; i < CONV_LAT; i++) begin
         inflight = inflight + (CNT_W+1)'(tag[i]);
      end
   end

   assign conv_rst     = conv_rst_q | clr;
   assign in_ready     = !conv_rst && (inflight < (CNT_W+1)'(FIFO_DEPTH));
   assign in_fire      = in_valid & in_ready;
   assign conv_data_in = in_rgb;
   // Keep clocking the converter until every tagged pixel has reached the FIFO.
   assign conv_enable  = in_fire | (tag != '0);
   assign push         = tag[CONV_LAT-1] & ~clr;

   assign out_valid     = (fifo_count != '0);
   assign pop           = out_valid & out_ready;
   assign out_ycc       = out_valid ? fifo_head : '0;
   assign pix_last      = (pix == PIX_W'(BLK_PIX - 1));
   assign blk_last      = (blk == BLK_W'(BLK_PER_FRAME - 1));
   assign out_blk_first = out_valid & (pix == '0);
   assign out_blk_last  = out_valid & pix_last;
   assign out_frm_last  = out_valid & pix_last & blk_last;
   assign busy          = (tag != '0) | out_valid | conv_rst;

   // Tag pipe, converter reset stretch and output position counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag        <= '0;
         conv_rst_q <= 1'b1;
         pix        <= '0;
         blk        <= '0;
      end else if (clr) begin
         tag        <= '0;
         conv_rst_q <= 1'b1;
         pix        <= '0;
         blk        <= '0;
      end else begin
         conv_rst_q <= 1'b0;
         if (conv_enable) tag <= {tag[CONV_LAT-2:0], in_fire};
         if (pop) begin
            if (pix_last) begin
               pix <= '0;
               blk <= blk_last ? '0 : blk + BLK_W'(1);
            end else begin
               pix <= pix + PIX_W'(1);
            end
         end
      end
   end

   ycc_sync_fifo #(
      .WIDTH ($bits(ycc_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .push   (push),
      .din    (conv_data_out),
      .pop    (pop),
      .head_c (fifo_head),
      .count  (fifo_count)
   );

endmodule
